flt2fix_seq: RTL and testbench

- Synthesizable, multi-operand successor to the behavioural half-float to fixed converter.
- Walks NUM_OPS IEEE-754 binary16 operands stored little-endian in byte-wide data memory. Converts each to a 16-bit fixed-point value with FRAC_BITS fraction bits. Writes the results back to memory.
- Output format is selectable per run: sign-magnitude (legacy) or two's complement.
- Sits beside data_mem as a bus master, started and acknowledged by the top-level start/done handshake.

---
 rtl/flt2fix_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_flt2fix_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flt2fix_seq.sv
// flt2fix_seq: sequential binary16 -> 16-bit fixed-point converter.
// Acts as a byte-wide bus master beside data_mem. It reads NUM_OPS little-endian
// half-float operands from SRC_BASE, converts each one to fixed point with
// FRAC_BITS fraction bits, and writes the results little-endian to DST_BASE.
// The result is sign-magnitude or two's complement, chosen per run by tc_mode.
// Optional build macro FLT2FIX_ROUND_EN: when it is defined, the bits shifted
// out are rounded half-to-even instead of truncated. Latency does not change.

module flt2fix_seq #(
    parameter int FRAC_BITS = 8,
    parameter int NUM_OPS   = 1,
    parameter int SRC_BASE  = 4,
    parameter int DST_BASE  = 6,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tc_mode,
    output logic              done,
    output logic              busy,
    output logic [7:0]        sat_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CAP,
        S_CALC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    // The exponent at which the mantissa integer needs no shift: e_eff - 25 + FRAC_BITS == 0
    localparam logic [5:0]        BIAS_OFF = 6'(25 - FRAC_BITS);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [6:0]        LAST_OP  = 7'(NUM_OPS - 1);

    state_t      state_q, state_d;
    logic        start_q;
    logic        tcMode_q, tcMode_d;
    logic [6:0]  opIdx_q, opIdx_d;
    logic [7:0]  loByte_q, loByte_d;
    logic [7:0]  hiByte_q, hiByte_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  satCnt_q, satCnt_d;

    logic [ADDR_W-1:0] opOff;
    logic [ADDR_W-1:0] srcAddr;
    logic [ADDR_W-1:0] dstAddr;
    logic              lastOp;
    logic              launch;

    logic [15:0] fWord;
    logic        sgn;
    logic [4:0]  expo;
    logic [4:0]  expEff;
    logic [5:0]  expEff6;
    logic [10:0] mant;
    logic [41:0] mantWide;
    logic [5:0]  shAmt;
    logic [41:0] magWide;
    logic [41:0] magRnd;
    logic        roundUp;
    logic        convSat;
    logic [14:0] convMag;
    logic [15:0] magS;
    logic [15:0] negS;
    logic [15:0] convResult;
`ifdef FLT2FIX_ROUND_EN
    logic        halfBit;
    logic        sticky;
    logic [41:0] stickyMask;
`endif

    // Operand and result addresses advance two bytes per operand and wrap with the address width
    always_comb begin
        opOff   = ADDR_W'({opIdx_q, 1'b0});
        srcAddr = SRC_A + opOff;
        dstAddr = DST_A + opOff;
        lastOp  = (opIdx_q == LAST_OP);
        launch  = start_q && !start;
    end

    // Half-float decode, scale by a power of two, optional rounding, then clamp and format
    always_comb begin
        fWord      = {hiByte_q, loByte_q};
        sgn        = fWord[15];
        expo       = fWord[14:10];
        mant       = {(expo != 5'd0), fWord[9:0]};
        expEff     = (expo == 5'd0) ? 5'd1 : expo;
        expEff6    = {1'b0, expEff};
        mantWide   = {31'd0, mant};
        shAmt      = 6'd0;
        magWide    = 42'd0;
        roundUp    = 1'b0;
`ifdef FLT2FIX_ROUND_EN
        halfBit    = 1'b0;
        sticky     = 1'b0;
        stickyMask = 42'd0;
`endif
        if (expEff6 >= BIAS_OFF) begin
            shAmt   = expEff6 - BIAS_OFF;
            magWide = mantWide << shAmt;
        end else begin
            shAmt   = BIAS_OFF - expEff6;
            magWide = mantWide >> shAmt;
`ifdef FLT2FIX_ROUND_EN
            halfBit    = mantWide[shAmt - 6'd1];
            stickyMask = (42'd1 << (shAmt - 6'd1)) - 42'd1;
            sticky     = |(mantWide & stickyMask);
            roundUp    = halfBit && (sticky || magWide[0]);
`endif
        end
        magRnd     = magWide + {41'd0, roundUp};
        convSat    = (expo == 5'h1F) || (magRnd > 42'h7FFF);
        convMag    = convSat ? 15'h7FFF : magRnd[14:0];
        magS       = {1'b0, convMag};
        negS       = (~magS) + 16'd1;
        if (tcMode_q) begin
            convResult = sgn ? negS : magS;
        end else begin
            convResult = {sgn, convMag};
        end
    end

    // Next-state and bus control: one read per operand byte, one write per result byte
    always_comb begin
        state_d     = state_q;
        tcMode_d    = tcMode_q;
        opIdx_d     = opIdx_q;
        loByte_d    = loByte_q;
        hiByte_d    = hiByte_q;
        result_d    = result_q;
        satCnt_d    = satCnt_q;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        sat_cnt     = satCnt_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d  = S_RD_LO;
                    opIdx_d  = 7'd0;
                    satCnt_d = 8'd0;
                    tcMode_d = tc_mode;
                end
            end
            S_RD_LO: begin
                mem_rd_en = 1'b1;
                mem_addr  = srcAddr;
                state_d   = S_RD_HI;
            end
            S_RD_HI: begin
                mem_rd_en = 1'b1;
                mem_addr  = srcAddr + ONE_A;
                loByte_d  = mem_rd_data;
                state_d   = S_CAP;
            end
            S_CAP: begin
                hiByte_d = mem_rd_data;
                state_d  = S_CALC;
            end
            S_CALC: begin
                result_d = convResult;
                if (convSat && (satCnt_q != 8'hFF)) begin
                    satCnt_d = satCnt_q + 8'd1;
                end
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dstAddr;
                mem_wr_data = result_q[7:0];
                state_d     = S_WR_HI;
            end
            S_WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dstAddr + ONE_A;
                mem_wr_data = result_q[15:8];
                if (lastOp) begin
                    state_d = S_DONE;
                end else begin
                    opIdx_d = opIdx_q + 7'd1;
                    state_d = S_RD_LO;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any run in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            tcMode_q <= 1'b0;
            opIdx_q  <= 7'd0;
            loByte_q <= 8'd0;
            hiByte_q <= 8'd0;
            result_q <= 16'd0;
            satCnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            tcMode_q <= tcMode_d;
            opIdx_q  <= opIdx_d;
            loByte_q <= loByte_d;
            hiByte_q <= hiByte_d;
            result_q <= result_d;
            satCnt_q <= satCnt_d;
        end
    end

endmodule

// File: tb/tb_flt2fix_seq.sv
// Testbench for flt2fix_seq. It uses three instances that share clock, reset,
// start and tc_mode, and each instance has its own byte memory:
//   inst 0: FRAC_BITS=8,  NUM_OPS=1, SRC_BASE=4,  DST_BASE=6
//   inst 1: FRAC_BITS=15, NUM_OPS=1, SRC_BASE=4,  DST_BASE=6
//   inst 2: FRAC_BITS=8,  NUM_OPS=3, SRC_BASE=16, DST_BASE=32
// Expected results are written out by hand from the binary16 definition.
// The FLT2FIX_ROUND_EN macro selects the rounding expectations.

module tb_flt2fix_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       tcMode;
    logic [2:0] done;
    logic [2:0] busy;
    logic [2:0] rdEn;
    logic [2:0] wrEn;
    logic [7:0] satCnt  [3];
    logic [7:0] memAddr [3];
    logic [7:0] rdData  [3];
    logic [7:0] wrData  [3];
    logic [7:0] mem     [3][256];

    logic       tbWe;
    logic [1:0] tbSel;
    logic [7:0] tbAddr;
    logic [7:0] tbData;

    int total = 0;
    int bad   = 0;
    int lastLat   [3];
    int doneCnt   [3];
    logic busyAtDone [3];

    flt2fix_seq #(.FRAC_BITS(8), .NUM_OPS(1), .SRC_BASE(4), .DST_BASE(6), .ADDR_W(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .tc_mode(tcMode),
        .done(done[0]), .busy(busy[0]), .sat_cnt(satCnt[0]),
        .mem_addr(memAddr[0]), .mem_rd_en(rdEn[0]), .mem_rd_data(rdData[0]),
        .mem_wr_en(wrEn[0]), .mem_wr_data(wrData[0])
    );

    flt2fix_seq #(.FRAC_BITS(15), .NUM_OPS(1), .SRC_BASE(4), .DST_BASE(6), .ADDR_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start), .tc_mode(tcMode),
        .done(done[1]), .busy(busy[1]), .sat_cnt(satCnt[1]),
        .mem_addr(memAddr[1]), .mem_rd_en(rdEn[1]), .mem_rd_data(rdData[1]),
        .mem_wr_en(wrEn[1]), .mem_wr_data(wrData[1])
    );

    flt2fix_seq #(.FRAC_BITS(8), .NUM_OPS(3), .SRC_BASE(16), .DST_BASE(32), .ADDR_W(8)) dut2 (
        .clk(clk), .reset(reset), .start(start), .tc_mode(tcMode),
        .done(done[2]), .busy(busy[2]), .sat_cnt(satCnt[2]),
        .mem_addr(memAddr[2]), .mem_rd_en(rdEn[2]), .mem_rd_data(rdData[2]),
        .mem_wr_en(wrEn[2]), .mem_wr_data(wrData[2])
    );

    // Byte memories: one-cycle read latency, plus a bench write port for preloading
    always @(posedge clk) begin
        if (tbWe) mem[tbSel][tbAddr] <= tbData;
        for (int k = 0; k < 3; k++) begin
            if (wrEn[k]) mem[k][memAddr[k]] <= wrData[k];
            if (rdEn[k]) rdData[k] <= mem[k][memAddr[k]];
        end
    end

    function automatic logic [15:0] peekWord(input int k, input int a);
        return {mem[k][a + 1], mem[k][a]};
    endfunction

    task automatic pokeWord(input int k, input int a, input logic [15:0] w);
        @(negedge clk);
        tbWe = 1'b1; tbSel = k[1:0]; tbAddr = a[7:0]; tbData = w[7:0];
        @(negedge clk);
        tbAddr = 8'(a + 1); tbData = w[15:8];
        @(negedge clk);
        tbWe = 1'b0;
    endtask

    // Pulse start, then watch a fixed window. The latency is counted from the cycle in which start falls.
    task automatic launchRun;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lastLat[k] = -1; doneCnt[k] = 0; busyAtDone[k] = 1'b0;
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done[k] === 1'b1) begin
                    doneCnt[k]++;
                    if (lastLat[k] < 0) begin
                        lastLat[k] = c;
                        busyAtDone[k] = busy[k];
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (done !== 3'b000) begin bad++; $display("[TB] FAIL reset_done: got %b want 000", done); end
        total++; if (busy !== 3'b000) begin bad++; $display("[TB] FAIL reset_busy: got %b want 000", busy); end
        total++; if (satCnt[0] !== 8'd0) begin bad++; $display("[TB] FAIL reset_sat: got %h want 00", satCnt[0]); end
        total++; if (rdEn !== 3'b000) begin bad++; $display("[TB] FAIL reset_rden: got %b want 000", rdEn); end
        total++; if (wrEn !== 3'b000) begin bad++; $display("[TB] FAIL reset_wren: got %b want 000", wrEn); end
        total++; if (memAddr[0] !== 8'd0) begin bad++; $display("[TB] FAIL reset_addr: got %h want 00", memAddr[0]); end
        total++; if (wrData[0] !== 8'd0) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 00", wrData[0]); end
    endtask

    task automatic test_basic;
        pokeWord(0, 4, 16'h3C00);
        tcMode = 1'b0;
        launchRun();
        total++; if (peekWord(0, 6) !== 16'h0100) begin bad++; $display("[TB] FAIL basic_result: got %h want 0100", peekWord(0, 6)); end
        total++; if (lastLat[0] != 7) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 7", lastLat[0]); end
        total++; if (doneCnt[0] != 1) begin bad++; $display("[TB] FAIL basic_done_count: got %0d want 1", doneCnt[0]); end
        total++; if (busyAtDone[0] !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_at_done: got %b want 1", busyAtDone[0]); end
        total++; if (satCnt[0] !== 8'd0) begin bad++; $display("[TB] FAIL basic_sat: got %h want 00", satCnt[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after: got %b want 0", busy[0]); end
    endtask

    task automatic test_signs;
        pokeWord(0, 4, 16'hC100);
        tcMode = 1'b0;
        launchRun();
        total++; if (peekWord(0, 6) !== 16'h8280) begin bad++; $display("[TB] FAIL neg_sm: got %h want 8280", peekWord(0, 6)); end
        tcMode = 1'b1;
        launchRun();
        total++; if (peekWord(0, 6) !== 16'hFD80) begin bad++; $display("[TB] FAIL neg_tc: got %h want FD80", peekWord(0, 6)); end
        total++; if (satCnt[0] !== 8'd0) begin bad++; $display("[TB] FAIL neg_sat: got %h want 00", satCnt[0]); end
    endtask

    task automatic test_saturation;
        pokeWord(0, 4, 16'h5800);
        tcMode = 1'b0;
        launchRun();
        total++; if (peekWord(0, 6) !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_pos: got %h want 7FFF", peekWord(0, 6)); end
        total++; if (satCnt[0] !== 8'd1) begin bad++; $display("[TB] FAIL sat_pos_cnt: got %h want 01", satCnt[0]); end
        pokeWord(0, 4, 16'hFC00);
        launchRun();
        total++; if (peekWord(0, 6) !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_ninf_sm: got %h want FFFF", peekWord(0, 6)); end
        total++; if (satCnt[0] !== 8'd1) begin bad++; $display("[TB] FAIL sat_ninf_cnt: got %h want 01", satCnt[0]); end
        tcMode = 1'b1;
        launchRun();
        total++; if (peekWord(0, 6) !== 16'h8001) begin bad++; $display("[TB] FAIL sat_ninf_tc: got %h want 8001", peekWord(0, 6)); end
    endtask

    task automatic test_rounding;
        logic [15:0] expTie;
`ifdef FLT2FIX_ROUND_EN
        expTie = 16'h0102;
`else
        expTie = 16'h0101;
`endif
        tcMode = 1'b0;
        pokeWord(0, 4, 16'h3C06);
        launchRun();
        total++; if (peekWord(0, 6) !== expTie) begin bad++; $display("[TB] FAIL round_3c06: got %h want %h", peekWord(0, 6), expTie); end
        pokeWord(0, 4, 16'h3C02);
        launchRun();
        total++; if (peekWord(0, 6) !== 16'h0100) begin bad++; $display("[TB] FAIL round_3c02: got %h want 0100", peekWord(0, 6)); end
        total++; if (satCnt[0] !== 8'd0) begin bad++; $display("[TB] FAIL round_sat_cleared: got %h want 00", satCnt[0]); end
    endtask

    task automatic test_frac15;
        tcMode = 1'b0;
        pokeWord(1, 4, 16'h0200);
        launchRun();
        total++; if (peekWord(1, 6) !== 16'h0001) begin bad++; $display("[TB] FAIL f15_denorm: got %h want 0001", peekWord(1, 6)); end
        pokeWord(1, 4, 16'h8000);
        launchRun();
        total++; if (peekWord(1, 6) !== 16'h8000) begin bad++; $display("[TB] FAIL f15_negzero_sm: got %h want 8000", peekWord(1, 6)); end
        tcMode = 1'b1;
        launchRun();
        total++; if (peekWord(1, 6) !== 16'h0000) begin bad++; $display("[TB] FAIL f15_negzero_tc: got %h want 0000", peekWord(1, 6)); end
    endtask

    task automatic loadMulti;
        pokeWord(2, 16, 16'h3C00);
        pokeWord(2, 18, 16'h5800);
        pokeWord(2, 20, 16'hC100);
        pokeWord(2, 32, 16'h0000);
        pokeWord(2, 34, 16'h0000);
        pokeWord(2, 36, 16'h0000);
    endtask

    task automatic test_multi;
        loadMulti();
        tcMode = 1'b0;
        launchRun();
        total++; if (peekWord(2, 32) !== 16'h0100) begin bad++; $display("[TB] FAIL multi_r0: got %h want 0100", peekWord(2, 32)); end
        total++; if (peekWord(2, 34) !== 16'h7FFF) begin bad++; $display("[TB] FAIL multi_r1: got %h want 7FFF", peekWord(2, 34)); end
        total++; if (peekWord(2, 36) !== 16'h8280) begin bad++; $display("[TB] FAIL multi_r2: got %h want 8280", peekWord(2, 36)); end
        total++; if (satCnt[2] !== 8'd1) begin bad++; $display("[TB] FAIL multi_sat: got %h want 01", satCnt[2]); end
        total++; if (lastLat[2] != 19) begin bad++; $display("[TB] FAIL multi_latency: got %0d want 19", lastLat[2]); end
        total++; if (doneCnt[2] != 1) begin bad++; $display("[TB] FAIL multi_done_count: got %0d want 1", doneCnt[2]); end
    endtask

    // Reset arrives in cycle 9 after launch, while operand 1 is being read. The first result is already written.
    task automatic test_reset_midrun;
        int seenDone;
        loadMulti();
        tcMode = 1'b0;
        seenDone = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (done[2] === 1'b1) seenDone++;
        end
        total++; if (busy[2] !== 1'b1) begin bad++; $display("[TB] FAIL midrun_busy_before: got %b want 1", busy[2]); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy[2] !== 1'b0) begin bad++; $display("[TB] FAIL midrun_busy_drop: got %b want 0", busy[2]); end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done[2] === 1'b1) seenDone++;
        end
        total++; if (seenDone != 0) begin bad++; $display("[TB] FAIL midrun_no_done: got %0d want 0", seenDone); end
        total++; if (peekWord(2, 32) !== 16'h0100) begin bad++; $display("[TB] FAIL midrun_r0: got %h want 0100", peekWord(2, 32)); end
        total++; if (peekWord(2, 34) !== 16'h0000) begin bad++; $display("[TB] FAIL midrun_r1: got %h want 0000", peekWord(2, 34)); end
    endtask

    task automatic test_start_held;
        int sawBusy;
        sawBusy = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy !== 3'b000) sawBusy++;
        end
        total++; if (sawBusy != 0) begin bad++; $display("[TB] FAIL held_no_launch: got %0d busy cycles want 0", sawBusy); end
        start = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int nDone;
        nDone = 0;
        pokeWord(0, 4, 16'h3C00);
        tcMode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
            if (done[0] === 1'b1) nDone++;
        end
        total++; if (nDone != 1) begin bad++; $display("[TB] FAIL busy_edge_ignored: got %0d done pulses want 1", nDone); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("[TB] FAIL busy_edge_idle: got %b want 0", busy[0]); end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        tcMode = 1'b0;
        tbWe   = 1'b0;
        tbSel  = 2'd0;
        tbAddr = 8'd0;
        tbData = 8'd0;
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_rounding();
        test_frac15();
        test_multi();
        test_reset_midrun();
        test_start_held();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
